// File: rtl/kanagawa_hal_fifo_drain_skid_if.sv
// FIFO-drain bundle: show-ahead FIFO read side in, registered valid/ready stream out.
// master = drain block, slave = FIFO/consumer side.
interface kanagawa_hal_fifo_drain_skid_if #(
  parameter int WIDTH = 32
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_rdreq;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    input  fifo_empty, fifo_q, flush, out_ready,
    output fifo_rdreq, out_valid, out_data, occupancy
  );

  modport slave (
    output fifo_empty, fifo_q, flush, out_ready,
    input  fifo_rdreq, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/kanagawa_hal_fifo_drain_skid.sv
// Show-ahead FIFO drain into a 2-entry registered skid buffer.
// Optional beat/stall counters: define KANAGAWA_FIFO_DRAIN_STATS_EN.
module kanagawa_hal_fifo_drain_skid #(
  parameter int WIDTH = 32
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
  , parameter int STATS_WIDTH = 32
`endif
) (
  input  logic clock,
  input  logic rst_n,
  kanagawa_hal_fifo_drain_skid_if.master bus
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
  , output logic [STATS_WIDTH-1:0] stat_beats
  , output logic [STATS_WIDTH-1:0] stat_stalls
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             run_q;
  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic             push, pop;

  // rdreq never looks at out_ready; that is the whole point
  assign push = run_q && !bus.fifo_empty
             && !bus.flush && (state_q != TWO);
  assign pop  = (state_q != EMPTY) && bus.out_ready;

  assign bus.fifo_rdreq = push;
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_data   = entry0_q;
  assign bus.occupancy  = state_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      run_q    <= 1'b0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          entry0_d = bus.fifo_q;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          entry0_d = bus.fifo_q;
        end else if (push) begin
          entry1_d = bus.fifo_q;
          state_d  = TWO;
        end else if (pop) begin
          state_d  = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          entry0_d = entry1_q;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) state_d = EMPTY;
  end

`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
  logic [STATS_WIDTH-1:0] beats_q, beats_d;
  logic [STATS_WIDTH-1:0] stalls_q, stalls_d;
  logic                   stall;

  assign stall = (state_q != EMPTY) && !bus.out_ready;

  // saturating; flush deliberately leaves them alone
  always_comb begin
    beats_d  = beats_q;
    stalls_d = stalls_q;
    if (pop && (beats_q != '1))
      beats_d = beats_q + 1'b1;
    if (stall && (stalls_q != '1))
      stalls_d = stalls_q + 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      beats_q  <= beats_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_kanagawa_hal_fifo_drain_skid.sv
// Bench for kanagawa_hal_fifo_drain_skid: vector table, corner sequences,
// random traffic against a queue-based model of FIFO and buffer.
module tb_kanagawa_hal_fifo_drain_skid;
  localparam int W = 32;
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;
  logic [SW-1:0] stat_beats, stat_stalls;
  int mb, ms;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kanagawa_hal_fifo_drain_skid_if #(.WIDTH(W)) bus ();

  kanagawa_hal_fifo_drain_skid #(
    .WIDTH(W)
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
    , .STATS_WIDTH(SW)
`endif
  ) dut (
    .clock(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
    , .stat_beats(stat_beats)
    , .stat_stalls(stat_stalls)
`endif
  );

  typedef struct {
    bit          add;
    logic [31:0] word;
    bit          fl;
    bit          rdy;
    bit          e_rd;
    bit          e_v;
    logic [1:0]  e_occ;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[16];
  logic [31:0] fq[$];
  logic [31:0] sb[$];
  bit run;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    run = 0;
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
    mb = 0;
    ms = 0;
`endif
  endtask

  // One clock: drive, sample at negedge, check, advance model at posedge.
  task automatic step(input bit fl, input bit rdy,
                      output bit o_rd, output bit o_v,
                      output logic [1:0] o_occ,
                      output logic [31:0] o_data);
    bit e_rd, e_v;
    bus.flush      = fl;
    bus.out_ready  = rdy;
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_q     = (fq.size() != 0) ? fq[0] : 32'h0;
    @(negedge clk);
    e_rd = rst_n && run && (fq.size() != 0)
        && !fl && (sb.size() < 2);
    e_v  = (sb.size() != 0);
    o_rd = bus.fifo_rdreq;
    o_v = bus.out_valid;
    o_occ = bus.occupancy;
    o_data = bus.out_data;
    chk("rdreq", {31'b0, o_rd}, {31'b0, e_rd});
    chk("valid", {31'b0, o_v}, {31'b0, e_v});
    chk("occ", {30'b0, o_occ}, sb.size());
    if (e_v) chk("data", o_data, sb[0]);
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
    chk("stat_beats", {28'b0, stat_beats}, mb);
    chk("stat_stalls", {28'b0, stat_stalls}, ms);
`endif
    @(posedge clk);
    if (rst_n) begin
      if (e_v && rdy) void'(sb.pop_front());
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
      if (e_v && rdy && mb < SMAX) mb++;
      if (e_v && !rdy && ms < SMAX) ms++;
`endif
      if (e_rd) sb.push_back(fq.pop_front());
      if (fl) sb.delete();
      run = 1;
    end
    #1;
  endtask

  bit rd, v;
  logic [1:0] occ;
  logic [31:0] dat;

  task automatic drain();
    for (int i = 0; i < 20; i++)
      if (sb.size() != 0 || fq.size() != 0)
        step(0, 1, rd, v, occ, dat);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 1, 1, 1, 32'h11};
    tbl[3]  = '{0, 0, 0, 1, 1, 1, 1, 32'h22};
    tbl[4]  = '{0, 0, 0, 1, 0, 1, 1, 32'h33};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 32'hA0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 32'hA1, 0, 0, 1, 1, 1, 32'hA0};
    tbl[8]  = '{1, 32'hA2, 0, 0, 0, 1, 2, 32'hA0};
    tbl[9]  = '{1, 32'hA3, 0, 0, 0, 1, 2, 32'hA0};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 2, 32'hA0};
    tbl[11] = '{0, 0, 0, 1, 0, 1, 2, 32'hA0};
    tbl[12] = '{0, 0, 0, 1, 1, 1, 1, 32'hA1};
    tbl[13] = '{0, 0, 0, 1, 1, 1, 1, 32'hA2};
    tbl[14] = '{0, 0, 0, 1, 0, 1, 1, 32'hA3};
    tbl[15] = '{0, 0, 0, 1, 0, 0, 0, 0};

    bus.flush = 0;
    bus.out_ready = 0;
    bus.fifo_empty = 1;
    bus.fifo_q = 0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_occ", {30'b0, bus.occupancy}, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_rdreq", {31'b0, bus.fifo_rdreq}, 0);

    // vector table: A,B,C streaming, then 4 words against backpressure
    fq.push_back(32'h11);
    fq.push_back(32'h22);
    fq.push_back(32'h33);
    @(posedge clk);
    #1 rst_n = 1;
    foreach (tbl[i]) begin
      if (tbl[i].add) fq.push_back(tbl[i].word);
      step(tbl[i].fl, tbl[i].rdy, rd, v, occ, dat);
      chk($sformatf("tbl%0d_rd", i), {31'b0, rd}, {31'b0, tbl[i].e_rd});
      chk($sformatf("tbl%0d_v", i), {31'b0, v}, {31'b0, tbl[i].e_v});
      chk($sformatf("tbl%0d_occ", i), {30'b0, occ}, {30'b0, tbl[i].e_occ});
      if (tbl[i].e_v)
        chk($sformatf("tbl%0d_data", i), dat, tbl[i].e_data);
    end

    // flush while full and head accepted
    fq.push_back(32'hB0);
    fq.push_back(32'hB1);
    fq.push_back(32'hB2);
    step(0, 0, rd, v, occ, dat);
    step(0, 0, rd, v, occ, dat);
    step(1, 1, rd, v, occ, dat);
    chk("flush_rd", {31'b0, rd}, 0);
    chk("flush_occ", {30'b0, occ}, 2);
    chk("flush_head", dat, 32'hB0);
    step(0, 0, rd, v, occ, dat);
    chk("postflush_v", {31'b0, v}, 0);
    chk("postflush_occ", {30'b0, occ}, 0);
    chk("postflush_rd", {31'b0, rd}, 1);
    drain();

    // single word into empty FIFO
    repeat (3) step(0, 0, rd, v, occ, dat);
    fq.push_back(32'h5A);
    step(0, 0, rd, v, occ, dat);
    chk("single_rd", {31'b0, rd}, 1);
    step(0, 0, rd, v, occ, dat);
    chk("single_rd2", {31'b0, rd}, 0);
    chk("single_v", {31'b0, v}, 1);
    chk("single_data", dat, 32'h5A);
    drain();

    // async reset at occupancy 2
    for (int i = 0; i < 4; i++) fq.push_back(32'hC0 + i);
    repeat (3) step(0, 0, rd, v, occ, dat);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {31'b0, bus.out_valid}, 0);
    chk("arst_occ", {30'b0, bus.occupancy}, 0);
    model_reset();
    repeat (2) step(0, 1, rd, v, occ, dat);
    rst_n = 1;
    step(0, 1, rd, v, occ, dat);
    chk("rel_rd", {31'b0, rd}, 0);
    step(0, 1, rd, v, occ, dat);
    step(0, 1, rd, v, occ, dat);
    chk("resume_data", dat, 32'hC2);
    drain();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2) == 0 && fq.size() < 8)
        fq.push_back($urandom);
      step($urandom_range(11) == 0, $urandom_range(3) != 0,
           rd, v, occ, dat);
    end
    drain();

`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
    // stall saturation, then beats from a fresh reset
    rst_n = 0;
    model_reset();
    repeat (2) step(0, 0, rd, v, occ, dat);
    rst_n = 1;
    for (int i = 0; i < 3; i++) fq.push_back(32'hD0 + i);
    repeat (20) step(0, 0, rd, v, occ, dat);
    chk("stalls_sat", {28'b0, stat_stalls}, 15);
    repeat (3) step(0, 1, rd, v, occ, dat);
    chk("beats3", {28'b0, stat_beats}, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
